// File: rtl/alsu_pkg.sv
// Shared definitions for the ALSU command sequencer: command field layout,
// opcode encodings and FSM state codes.
package alsu_pkg;

  localparam int CMD_W = 16;

  localparam int A_LSB         = 0;
  localparam int A_MSB         = 2;
  localparam int B_LSB         = 3;
  localparam int B_MSB         = 5;
  localparam int OPCODE_LSB    = 6;
  localparam int OPCODE_MSB    = 8;
  localparam int CIN_BIT       = 9;
  localparam int SERIAL_IN_BIT = 10;
  localparam int DIRECTION_BIT = 11;
  localparam int RED_OP_A_BIT  = 12;
  localparam int RED_OP_B_BIT  = 13;
  localparam int BYPASS_A_BIT  = 14;
  localparam int BYPASS_B_BIT  = 15;

  localparam logic [2:0] OP_AND   = 3'd0;
  localparam logic [2:0] OP_XOR   = 3'd1;
  localparam logic [2:0] OP_ADD   = 3'd2;
  localparam logic [2:0] OP_MUL   = 3'd3;
  localparam logic [2:0] OP_SHIFT = 3'd4;
  localparam logic [2:0] OP_ROT   = 3'd5;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_WAIT = 2'd1;
  localparam state_t ST_RESP = 2'd2;

endpackage

// File: rtl/alsu_cmd_fifo.sv
// Synchronous command FIFO with registered level; no fall-through, so a word
// pushed into an empty FIFO is visible on rdata only after the push edge.
module alsu_cmd_fifo
  import alsu_pkg::*;
#(
  parameter int WIDTH = CMD_W,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok && !clr) mem[wr_ptr] <= wdata;
  end

  // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/alsu_cmd_sequencer.sv
// Feeds buffered ALSU commands onto the ALSU pins one at a time and returns the
// OUT/LEDS result, sampled a fixed latency later, with a sequence tag.
module alsu_cmd_sequencer
  import alsu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int LAT   = 2,
  parameter int TAG_W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     soft_clr,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [CMD_W-1:0]         cmd_data,
  output logic [2:0]               alsu_a,
  output logic [2:0]               alsu_b,
  output logic [2:0]               alsu_opcode,
  output logic                     alsu_cin,
  output logic                     alsu_serial_in,
  output logic                     alsu_direction,
  output logic                     alsu_red_op_a,
  output logic                     alsu_red_op_b,
  output logic                     alsu_bypass_a,
  output logic                     alsu_bypass_b,
  input  logic [5:0]               alsu_out,
  input  logic [15:0]              alsu_leds,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [5:0]               rsp_out,
  output logic [15:0]              rsp_leds,
  output logic                     rsp_err,
  output logic [TAG_W-1:0]         rsp_tag,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     busy
);

  localparam int CNT_W = (LAT < 1) ? 1 : $clog2(LAT + 1);

  logic [CMD_W-1:0] fifo_rdata;
  logic [CMD_W-1:0] drive_cmd;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [TAG_W-1:0] tag_cnt;
  logic [TAG_W-1:0] cur_tag;

  assign cmd_ready = !fifo_full;
  assign push      = cmd_valid && !fifo_full && !soft_clr;
  assign pop       = !soft_clr && !fifo_empty &&
                     ((state == ST_IDLE) || ((state == ST_RESP) && rsp_ready));
  assign busy      = (state != ST_IDLE);

  alsu_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (soft_clr),
    .push  (push),
    .pop   (pop),
    .wdata (cmd_data),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign alsu_a         = drive_cmd[A_MSB:A_LSB];
  assign alsu_b         = drive_cmd[B_MSB:B_LSB];
  assign alsu_opcode    = drive_cmd[OPCODE_MSB:OPCODE_LSB];
  assign alsu_cin       = drive_cmd[CIN_BIT];
  assign alsu_serial_in = drive_cmd[SERIAL_IN_BIT];
  assign alsu_direction = drive_cmd[DIRECTION_BIT];
  assign alsu_red_op_a  = drive_cmd[RED_OP_A_BIT];
  assign alsu_red_op_b  = drive_cmd[RED_OP_B_BIT];
  assign alsu_bypass_a  = drive_cmd[BYPASS_A_BIT];
  assign alsu_bypass_b  = drive_cmd[BYPASS_B_BIT];

  // A pop overrides the state chosen by the case, which is how RESP hands
  // straight over to WAIT when another command is already queued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      drive_cmd <= '0;
      tag_cnt   <= '0;
      cur_tag   <= '0;
      rsp_valid <= 1'b0;
      rsp_out   <= '0;
      rsp_leds  <= '0;
      rsp_err   <= 1'b0;
      rsp_tag   <= '0;
    end else if (soft_clr) begin
      state     <= ST_IDLE;
      rsp_valid <= 1'b0;
    end else begin
      case (state)
        ST_WAIT: begin
          if (cnt == '0) begin
            rsp_out   <= alsu_out;
            rsp_leds  <= alsu_leds;
            rsp_err   <= |alsu_leds;
            rsp_tag   <= cur_tag;
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: ;
      endcase
      if (pop) begin
        drive_cmd <= fifo_rdata;
        cur_tag   <= tag_cnt;
        tag_cnt   <= tag_cnt + 1'b1;
        cnt       <= CNT_W'(LAT);
        state     <= ST_WAIT;
      end
    end
  end

endmodule

// File: tb/tb_alsu_cmd_sequencer.sv
// Self-checking bench for alsu_cmd_sequencer: behavioural ALSU with two-edge
// latency, table-driven command stream and a response scoreboard.
module tb_alsu_cmd_sequencer;
  import alsu_pkg::*;

  localparam int DEPTH = 4;
  localparam int LAT   = 2;
  localparam int TAG_W = 4;
  localparam int LVL_W = $clog2(DEPTH) + 1;
  localparam int NVEC  = 12;

  logic              clk = 1'b0;
  logic              rst;
  logic              soft_clr;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [15:0]       cmd_data;
  logic [2:0]        alsu_a, alsu_b, alsu_opcode;
  logic              alsu_cin, alsu_serial_in, alsu_direction;
  logic              alsu_red_op_a, alsu_red_op_b, alsu_bypass_a, alsu_bypass_b;
  logic [5:0]        alsu_out;
  logic [15:0]       alsu_leds;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [5:0]        rsp_out;
  logic [15:0]       rsp_leds;
  logic              rsp_err;
  logic [TAG_W-1:0]  rsp_tag;
  logic [LVL_W-1:0]  fifo_level;
  logic              busy;

  always #5 clk = ~clk;

  alsu_cmd_sequencer #(.DEPTH(DEPTH), .LAT(LAT), .TAG_W(TAG_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .soft_clr       (soft_clr),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_data       (cmd_data),
    .alsu_a         (alsu_a),
    .alsu_b         (alsu_b),
    .alsu_opcode    (alsu_opcode),
    .alsu_cin       (alsu_cin),
    .alsu_serial_in (alsu_serial_in),
    .alsu_direction (alsu_direction),
    .alsu_red_op_a  (alsu_red_op_a),
    .alsu_red_op_b  (alsu_red_op_b),
    .alsu_bypass_a  (alsu_bypass_a),
    .alsu_bypass_b  (alsu_bypass_b),
    .alsu_out       (alsu_out),
    .alsu_leds      (alsu_leds),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_out        (rsp_out),
    .rsp_leds       (rsp_leds),
    .rsp_err        (rsp_err),
    .rsp_tag        (rsp_tag),
    .fifo_level     (fifo_level),
    .busy           (busy)
  );

  // Behavioural ALSU: inputs registered on one edge, OUT/LEDS on the next.
  logic [15:0] alsu_pins;
  logic [15:0] alsu_stage;
  assign alsu_pins = {alsu_bypass_b, alsu_bypass_a, alsu_red_op_b, alsu_red_op_a,
                      alsu_direction, alsu_serial_in, alsu_cin, alsu_opcode, alsu_b, alsu_a};

  function automatic logic [21:0] alsu_eval(input logic [15:0] c, input logic [5:0] prev);
    logic [2:0]  a, b, op;
    logic [5:0]  o;
    logic [15:0] l;
    a = c[2:0];
    b = c[5:3];
    op = c[8:6];
    o = prev;
    l = 16'h0000;
    if (op == 3'd6 || op == 3'd7 || ((c[12] || c[13]) && op > OP_XOR)) begin
      o = 6'd0;
      l = 16'hFFFF;
    end else if (c[14]) begin
      o = {3'b0, a};
    end else if (c[15]) begin
      o = {3'b0, b};
    end else begin
      case (op)
        OP_AND:   o = c[12] ? {5'b0, &a} : (c[13] ? {5'b0, &b} : {3'b0, a & b});
        OP_XOR:   o = c[12] ? {5'b0, ^a} : (c[13] ? {5'b0, ^b} : {3'b0, a ^ b});
        OP_ADD:   o = {3'b0, a} + {3'b0, b} + {5'b0, c[9]};
        OP_MUL:   o = {3'b0, a} * {3'b0, b};
        OP_SHIFT: o = c[11] ? {prev[4:0], c[10]} : {c[10], prev[5:1]};
        OP_ROT:   o = c[11] ? {prev[4:0], prev[5]} : {prev[0], prev[5:1]};
        default:  o = prev;
      endcase
    end
    return {l, o};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      alsu_stage <= 16'h0000;
      alsu_out   <= 6'd0;
      alsu_leds  <= 16'h0000;
    end else begin
      alsu_stage             <= alsu_pins;
      {alsu_leds, alsu_out}  <= alsu_eval(alsu_stage, alsu_out);
    end
  end

  typedef struct {
    logic [15:0] cmd;
    logic [5:0]  out;
    logic [15:0] leds;
  } vec_t;

  typedef struct {
    logic [5:0]  out;
    logic [15:0] leds;
    logic        err;
  } exp_t;

  vec_t             vecs [NVEC];
  exp_t             sb [$];
  exp_t             cur_exp;
  logic [TAG_W-1:0] next_tag;
  logic             accepted;
  int               checks = 0;
  int               errors = 0;
  int               cyc = 0;
  int               last_hs = 0;
  int               hs_gap = 0;

  function automatic logic [15:0] mk(input logic [2:0] a, input logic [2:0] b,
                                     input logic [2:0] op, input logic cin,
                                     input logic red_a, input logic red_b, input logic byp_a);
    logic [15:0] c;
    c = 16'h0000;
    c[2:0] = a;
    c[5:3] = b;
    c[8:6] = op;
    c[9]   = cin;
    c[12]  = red_a;
    c[13]  = red_b;
    c[14]  = byp_a;
    return c;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    cmd_valid = 1'b1;
    cmd_data  = v.cmd;
    cur_exp   = '{out: v.out, leds: v.leds, err: |v.leds};
  endtask

  // One clock: scoreboard work at the negedge, then advance to just past the posedge.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    if (rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_rsp actual=%0h required=none (cycle %0d)", rsp_out, cyc);
      end else begin
        e = sb.pop_front();
        checkOutput("rsp_out", 32'(rsp_out), 32'(e.out));
        checkOutput("rsp_leds", 32'(rsp_leds), 32'(e.leds));
        checkOutput("rsp_err", 32'(rsp_err), 32'(e.err));
        checkOutput("rsp_tag", 32'(rsp_tag), 32'(next_tag));
        next_tag = next_tag + 1'b1;
      end
      hs_gap  = cyc - last_hs;
      last_hs = cyc;
    end
    accepted = cmd_valid && cmd_ready && !soft_clr;
    if (accepted) sb.push_back(cur_exp);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    soft_clr  = 1'b0;
    cmd_valid = 1'b0;
    cmd_data  = 16'h0000;
    sb.delete();
    next_tag  = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drain(input int max);
    int k = 0;
    cmd_valid = 1'b0;
    while ((sb.size() != 0 || busy) && k < max) begin
      cycle();
      k++;
    end
    checkOutput("drain_timeout", 32'(k < max), 1);
  endtask

  task automatic wait_rsp_valid(input int max);
    int k = 0;
    while (!rsp_valid && k < max) begin
      cycle();
      k++;
    end
    checkOutput("rsp_valid_wait", 32'(rsp_valid), 1);
  endtask

  task automatic run_stream(input int n, input int first);
    int sent = 0;
    int budget = 0;
    while ((sent < n || sb.size() != 0 || busy) && budget < 3000) begin
      if (sent < n) applyStimulus(vecs[(first + sent) % NVEC]);
      else cmd_valid = 1'b0;
      cycle();
      if (accepted) sent++;
      budget++;
    end
    cmd_valid = 1'b0;
    checkOutput("stream_timeout", 32'(budget < 3000), 1);
  endtask

  initial begin
    vecs[0]  = '{mk(3'd3, 3'd5, OP_ADD, 1'b1, 1'b0, 1'b0, 1'b0), 6'd9,  16'h0000};
    vecs[1]  = '{mk(3'd7, 3'd7, OP_MUL, 1'b0, 1'b0, 1'b0, 1'b0), 6'd49, 16'h0000};
    vecs[2]  = '{mk(3'd5, 3'd0, OP_XOR, 1'b0, 1'b1, 1'b0, 1'b0), 6'd0,  16'h0000};
    vecs[3]  = '{mk(3'd0, 3'd0, 3'd6,   1'b0, 1'b0, 1'b0, 1'b0), 6'd0,  16'hFFFF};
    vecs[4]  = '{mk(3'd6, 3'd3, OP_AND, 1'b0, 1'b0, 1'b0, 1'b0), 6'd2,  16'h0000};
    vecs[5]  = '{mk(3'd6, 3'd3, OP_XOR, 1'b0, 1'b0, 1'b0, 1'b0), 6'd5,  16'h0000};
    vecs[6]  = '{mk(3'd7, 3'd7, OP_ADD, 1'b0, 1'b0, 1'b0, 1'b0), 6'd14, 16'h0000};
    vecs[7]  = '{mk(3'd5, 3'd2, OP_MUL, 1'b0, 1'b0, 1'b0, 1'b1), 6'd5,  16'h0000};
    vecs[8]  = '{mk(3'd1, 3'd2, OP_ADD, 1'b0, 1'b1, 1'b0, 1'b0), 6'd0,  16'hFFFF};
    vecs[9]  = '{mk(3'd0, 3'd7, OP_AND, 1'b0, 1'b0, 1'b1, 1'b0), 6'd1,  16'h0000};
    vecs[10] = '{mk(3'd2, 3'd4, 3'd7,   1'b0, 1'b0, 1'b0, 1'b0), 6'd0,  16'hFFFF};
    vecs[11] = '{mk(3'd6, 3'd5, OP_MUL, 1'b0, 1'b0, 1'b0, 1'b0), 6'd30, 16'h0000};

    rsp_ready = 1'b0;
    cur_exp   = '{out: 6'd0, leds: 16'h0000, err: 1'b0};
    accepted  = 1'b0;
    do_reset();

    $display("[TB] reset values");
    checkOutput("rst_drive", 32'(alsu_pins), 0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 0);
    checkOutput("rst_rsp_out", 32'(rsp_out), 0);
    checkOutput("rst_rsp_leds", 32'(rsp_leds), 0);
    checkOutput("rst_rsp_err", 32'(rsp_err), 0);
    checkOutput("rst_rsp_tag", 32'(rsp_tag), 0);
    checkOutput("rst_cmd_ready", 32'(cmd_ready), 1);
    checkOutput("rst_fifo_level", 32'(fifo_level), 0);
    checkOutput("rst_busy", 32'(busy), 0);

    $display("[TB] add latency");
    rsp_ready = 1'b1;
    applyStimulus(vecs[0]);
    cycle();
    cmd_valid = 1'b0;
    checkOutput("add_level_after_push", 32'(fifo_level), 1);
    checkOutput("add_idle_after_push", 32'(busy), 0);
    cycle();
    checkOutput("add_busy_after_pop", 32'(busy), 1);
    checkOutput("add_drive_a", 32'(alsu_a), 3);
    checkOutput("add_drive_opcode", 32'(alsu_opcode), 2);
    cycle();
    cycle();
    checkOutput("add_valid_lat", 32'(rsp_valid), 0);
    cycle();
    checkOutput("add_valid_lat1", 32'(rsp_valid), 1);
    cycle();
    checkOutput("add_valid_dropped", 32'(rsp_valid), 0);
    checkOutput("add_sb_empty", 32'(sb.size()), 0);

    $display("[TB] back-to-back mul / xor-reduce");
    do_reset();
    rsp_ready = 1'b1;
    applyStimulus(vecs[1]);
    cycle();
    applyStimulus(vecs[2]);
    cycle();
    drain(40);
    checkOutput("b2b_hs_gap", 32'(hs_gap), LAT + 2);

    $display("[TB] invalid opcode");
    do_reset();
    rsp_ready = 1'b1;
    run_stream(1, 3);

    $display("[TB] backpressure / full");
    do_reset();
    rsp_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i]);
      if (i == 5) checkOutput("bp_cmd_ready_full", 32'(cmd_ready), 0);
      cycle();
    end
    cmd_valid = 1'b0;
    checkOutput("bp_level", 32'(fifo_level), 4);
    checkOutput("bp_busy", 32'(busy), 1);
    wait_rsp_valid(10);
    for (int i = 0; i < 3; i++) begin
      checkOutput("bp_hold_out", 32'(rsp_out), 32'(vecs[0].out));
      checkOutput("bp_hold_tag", 32'(rsp_tag), 0);
      checkOutput("bp_hold_valid", 32'(rsp_valid), 1);
      cycle();
    end
    rsp_ready = 1'b1;
    drain(100);
    checkOutput("bp_level_drained", 32'(fifo_level), 0);

    $display("[TB] table stream with tag wrap");
    do_reset();
    rsp_ready = 1'b1;
    run_stream(17, 0);
    checkOutput("wrap_next_tag", 32'(next_tag), 1);

    $display("[TB] reset mid-operation");
    rsp_ready = 1'b1;
    applyStimulus(vecs[1]);
    cycle();
    cmd_valid = 1'b0;
    cycle();
    cycle();
    checkOutput("rst_mid_busy_before", 32'(busy), 1);
    rst = 1'b1;
    #1;
    checkOutput("rst_mid_drive", 32'(alsu_pins), 0);
    checkOutput("rst_mid_valid", 32'(rsp_valid), 0);
    checkOutput("rst_mid_busy", 32'(busy), 0);
    checkOutput("rst_mid_level", 32'(fifo_level), 0);
    checkOutput("rst_mid_tag", 32'(rsp_tag), 0);
    sb.delete();
    next_tag = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      checkOutput("rst_mid_no_rsp", 32'(rsp_valid), 0);
    end

    $display("[TB] soft_clr during RESP");
    rsp_ready = 1'b0;
    applyStimulus(vecs[4]);
    cycle();
    applyStimulus(vecs[5]);
    cycle();
    applyStimulus(vecs[6]);
    cycle();
    cmd_valid = 1'b0;
    wait_rsp_valid(10);
    checkOutput("clr_level_before", 32'(fifo_level), 2);
    soft_clr = 1'b1;
    applyStimulus(vecs[7]);
    cycle();
    soft_clr  = 1'b0;
    cmd_valid = 1'b0;
    checkOutput("clr_valid", 32'(rsp_valid), 0);
    checkOutput("clr_level", 32'(fifo_level), 0);
    checkOutput("clr_busy", 32'(busy), 0);
    checkOutput("clr_drive_kept", 32'(alsu_pins), 32'(vecs[4].cmd));
    sb.delete();
    next_tag = next_tag + 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      checkOutput("clr_no_rsp", 32'(rsp_valid), 0);
    end
    rsp_ready = 1'b1;
    run_stream(1, 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alsu_cmd_sequencer.md
Name: alsu_cmd_sequencer

Overview:
Upstream stage that feeds the ALSU datapath. It accepts packed ALSU commands over a valid/ready interface and buffers them in a small FIFO. Each command is driven onto the ALSU input pins, and the ALSU OUT/LEDS result is captured a fixed latency later and returned over a valid/ready response interface with a sequence tag. Only one command is in flight at a time.

Parameters:
DEPTH, 4, command FIFO entries (power of 2, >=2)
LAT, 2, clock edges from the pin-drive change until ALSU OUT/LEDS reflect the command
TAG_W, 4, width of the sequence tag

Ports:
clk  in  1  clock
rst  in  1  reset
soft_clr  in  1  synchronous flush of FIFO, FSM and response
cmd_valid  in  1  command offered
cmd_ready  out  1  FIFO can accept (= !full)
cmd_data  in  16  [2:0]A [5:3]B [8:6]OPCODE [9]CIN [10]SERIAL_IN [11]DIRECTION [12]RED_OP_A [13]RED_OP_B [14]BYPASSA [15]BYPASSB
alsu_a, alsu_b, alsu_opcode  out  3 each  drive to ALSU
alsu_cin, alsu_serial_in, alsu_direction, alsu_red_op_a, alsu_red_op_b, alsu_bypass_a, alsu_bypass_b  out  1 each  drive to ALSU
alsu_out  in  6  ALSU OUT
alsu_leds  in  16  ALSU LEDS
rsp_valid  out  1  result available
rsp_ready  in  1  consumer accepts
rsp_out  out  6  captured OUT
rsp_leds  out  16  captured LEDS
rsp_err  out  1  captured LEDS != 0 (invalid case flagged by ALSU)
rsp_tag  out  TAG_W  tag of the command that produced this result
fifo_level  out  clog2(DEPTH)+1  entries held
busy  out  1  FSM not IDLE

Behaviour:
- Reset rst: asynchronous, active-high; clock clk. Asynchronous reset, all state on posedge clk.
- Reset values: all ALSU drive outputs 0, rsp_valid 0, rsp_out/rsp_leds/rsp_err 0, rsp_tag 0, tag counter 0, FIFO empty (cmd_ready 1, fifo_level 0), FSM IDLE, busy 0.
- FIFO: push on cmd_valid&&cmd_ready. Pop is FSM-driven. Push and pop on the same edge are both allowed, level unchanged. A push into an empty FIFO can be popped at the earliest on the next edge (no fall-through). Pointers wrap modulo DEPTH.
- Drive registers are loaded only on a pop edge. They hold their value until the next pop. Between commands the ALSU therefore keeps seeing the last command, so shift/rotate ops keep evolving; this is harmless because the capture point is fixed.
- FSM states:
  - IDLE: if FIFO not empty, pop, load drive regs, latch tag = tag counter, increment tag counter (wraps), load cnt = LAT, go WAIT.
  - WAIT: cnt decrements each edge. On the edge where cnt==0, capture alsu_out/alsu_leds into the rsp regs, set rsp_err = |alsu_leds, assert rsp_valid, go RESP. The capture edge is exactly LAT+1 edges after the pop edge.
  - RESP: hold rsp_* stable while rsp_valid && !rsp_ready. On the edge with rsp_ready, drop rsp_valid. If the FIFO is non-empty on that same edge, pop and go WAIT directly (back-to-back). Otherwise go IDLE.
- Steady-state throughput with rsp_ready=1: one command per LAT+2 edges.
- soft_clr: takes priority over all other actions on that edge. It empties the FIFO, sends the FSM to IDLE, and clears rsp_valid. Drive regs and the tag counter are retained. A push on the same edge is dropped.
- Reset mid-operation: the in-flight command and all FIFO contents are lost. No response is produced.
- busy = (state != IDLE).

Decomposition:
- Shared package alsu_pkg: CMD_W=16; field LSB/MSB constants for cmd_data; opcode constants OP_AND=0, OP_XOR=1, OP_ADD=2, OP_MUL=3, OP_SHIFT=4, OP_ROT=5; FSM state enum (IDLE, WAIT, RESP).
- One sub-module, alsu_cmd_fifo: parameterised synchronous FIFO with full/empty/level outputs, instantiated once.

Test Plan:
- Add: cmd A=3, B=5, OPCODE=2, CIN=1, rsp_ready=1 -> rsp_valid rises exactly LAT+1 edges after the pop edge; rsp_out=9, rsp_err=0, rsp_tag=0.
- Multiply then XOR-reduce back-to-back: {A=7, B=7, OP=3} then {A=5, OP=1, RED_OP_A=1} -> rsp_out=49 (tag 0), then rsp_out=0 (tag 1); second pop occurs on the tag-0 handshake edge.
- Invalid op: OPCODE=6 after reset -> rsp_out=0, rsp_leds=16'hFFFF, rsp_err=1.
- Backpressure/full: rsp_ready=0, push 6 commands on consecutive cycles -> one command in flight, fifo_level reaches 4, cmd_ready=0, 6th push refused; rsp_* held stable until rsp_ready rises.
- Tag wrap: 17 commands -> rsp_tag sequence 0..15, then 0.
- Reset/flush mid-op: assert rst during WAIT -> all outputs return to reset values immediately, no rsp_valid afterwards. Assert soft_clr during RESP with 2 queued entries -> rsp_valid=0, fifo_level=0, busy=0 next cycle.
